mandel_pixel_sequencer: RTL and testbench

//  Front-end controller for the diverge iterator. Scans a WIDTH x HEIGHT pixel grid in raster order and

---
 rtl/mandel_pixel_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mandel_pixel_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mandel_pixel_sequencer.sv
// Mandelbrot front-end sequencer: walks a WIDTH x HEIGHT grid in raster order,
// loads each point c into the diverge iterator, counts iterations until escape
// or MAX_ITER, and hands one result per pixel downstream over valid/ready.
module mandel_pixel_sequencer #(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8,
    parameter int DIM_W    = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [31:0]       x_start,
    input  logic [31:0]       y_start,
    input  logic [31:0]       step,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [31:0]       c_re,
    output logic [31:0]       c_im,
    output logic              ld,
    input  logic              diverged,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DIM_W-1:0]  pix_x,
    output logic [DIM_W-1:0]  pix_y,
    output logic [ITER_W-1:0] pix_iter,
    output logic              pix_inset,
    output logic              busy,
    output logic              done
);

    localparam int                DATA_W = 32;
    localparam logic [ITER_W-1:0] K_MAX  = ITER_W'(MAX_ITER);
    localparam logic [DIM_W-1:0]  DIM_1  = DIM_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_EMIT} state_t;

    state_t                   state_q,   state_d;
    logic signed [DATA_W-1:0] xs_q,      xs_d;
    logic signed [DATA_W-1:0] ys_q,      ys_d;
    logic signed [DATA_W-1:0] step_q,    step_d;
    logic        [DIM_W-1:0]  w_q,       w_d;
    logic        [DIM_W-1:0]  h_q,       h_d;
    logic signed [DATA_W-1:0] c_re_q,    c_re_d;
    logic signed [DATA_W-1:0] c_im_q,    c_im_d;
    logic        [DIM_W-1:0]  px_q,      px_d;
    logic        [DIM_W-1:0]  py_q,      py_d;
    logic        [ITER_W-1:0] k_q,       k_d;
    logic        [ITER_W-1:0] iter_q,    iter_d;
    logic                     inset_q,   inset_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;

    logic last_col;
    logic last_row;

    // Modulo-2^32 add for stepping c; overflow is deliberately not detected.
    function automatic logic signed [DATA_W-1:0] c_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return a + b;
    endfunction

    assign last_col = (px_q == w_q - DIM_1);
    assign last_row = (py_q == h_q - DIM_1);

    // Next-state and datapath update for the scan/iterate/emit sequence.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        step_d  = step_q;
        w_d     = w_q;
        h_d     = h_q;
        c_re_d  = c_re_q;
        c_im_d  = c_im_q;
        px_d    = px_q;
        py_d    = py_q;
        k_d     = k_q;
        iter_d  = iter_q;
        inset_d = inset_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (width == '0 || height == '0) begin
                        // Empty frame: nothing to scan, report completion at once.
                        done_d = 1'b1;
                    end else begin
                        xs_d    = x_start;
                        ys_d    = y_start;
                        step_d  = step;
                        w_d     = width;
                        h_d     = height;
                        px_d    = '0;
                        py_d    = '0;
                        c_re_d  = x_start;
                        c_im_d  = y_start;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                k_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (diverged) begin
                    iter_d  = k_q;
                    inset_d = 1'b0;
                    state_d = S_EMIT;
                end else if (k_q == K_MAX) begin
                    iter_d  = K_MAX;
                    inset_d = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    k_d = k_q + ITER_W'(1);
                end
            end
            S_EMIT: begin
                if (pix_ready) begin
                    if (last_col && last_row) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (last_col) begin
                        px_d    = '0;
                        py_d    = py_q + DIM_1;
                        c_re_d  = xs_q;
                        c_im_d  = c_add(c_im_q, step_q);
                        state_d = S_LOAD;
                    end else begin
                        px_d    = px_q + DIM_1;
                        c_re_d  = c_add(c_re_q, step_q);
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            step_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            c_re_q  <= '0;
            c_im_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            k_q     <= '0;
            iter_q  <= '0;
            inset_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            step_q  <= step_d;
            w_q     <= w_d;
            h_q     <= h_d;
            c_re_q  <= c_re_d;
            c_im_q  <= c_im_d;
            px_q    <= px_d;
            py_q    <= py_d;
            k_q     <= k_d;
            iter_q  <= iter_d;
            inset_q <= inset_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ld holds the iterator cleared whenever no point is being iterated.
    assign ld        = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign pix_valid = (state_q == S_EMIT);
    assign c_re      = c_re_q;
    assign c_im      = c_im_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_iter  = iter_q;
    assign pix_inset = inset_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// Directed bench for mandel_pixel_sequencer with a behavioural Q11.21 diverge
// iterator (z <= z^2 + c, diverged when |z|^2 > 4.0) attached to the outputs.
module tb_mandel_pixel_sequencer;

    localparam int DIM_W  = 10;
    localparam int ITER_W = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              start;
    logic [31:0]       x_start, y_start, step;
    logic [DIM_W-1:0]  width, height;
    logic [31:0]       c_re, c_im;
    logic              ld;
    logic              diverged;
    logic              pix_valid;
    logic              pix_ready;
    logic [DIM_W-1:0]  pix_x, pix_y;
    logic [ITER_W-1:0] pix_iter;
    logic              pix_inset;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    mandel_pixel_sequencer #(.MAX_ITER(255), .ITER_W(ITER_W), .DIM_W(DIM_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .x_start(x_start), .y_start(y_start), .step(step),
        .width(width), .height(height),
        .c_re(c_re), .c_im(c_im), .ld(ld), .diverged(diverged),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter), .pix_inset(pix_inset),
        .busy(busy), .done(done)
    );

    always #5 aclk = ~aclk;

    // Diverge iterator model
    logic signed [31:0] zr = '0, zi = '0;
    logic signed [63:0] zr64, zi64, zr2, zi2, zri;
    logic signed [65:0] mag;
    localparam logic signed [65:0] FOUR_Q42 = 66'sd1 <<< 44;

    always_comb begin
        zr64 = zr;
        zi64 = zi;
        zr2  = zr64 * zr64;
        zi2  = zi64 * zi64;
        zri  = zr64 * zi64;
        mag  = 66'(zr2) + 66'(zi2);
    end
    assign diverged = (mag > FOUR_Q42);

    always @(posedge aclk) begin
        if (ld) begin
            zr <= '0;
            zi <= '0;
        end else begin
            zr <= 32'((zr2 - zi2) >>> 21) + $signed(c_re);
            zi <= 32'((zri <<< 1) >>> 21) + $signed(c_im);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [31:0] xs, input logic [31:0] ys,
                               input logic [31:0] st, input int w, input int h);
        @(negedge aclk);
        x_start = xs; y_start = ys; step = st;
        width = DIM_W'(w); height = DIM_W'(h);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        // Scramble config to prove it was captured at start
        x_start = 32'h1234_5678; y_start = 32'h0BAD_F00D; step = 32'h0000_0001;
        width = DIM_W'(7); height = DIM_W'(9);
    endtask

    // Wait for a result, optionally stall it, check payload and latency, accept it.
    task automatic get_pix(input string tag, input int ex, input int ey, input int eiter,
                           input int einset, input logic [31:0] ecre, input logic [31:0] ecim,
                           input int eiter_cyc, input int hold);
        int cyc = 0;
        int iter_cyc = 0;
        while (!pix_valid && cyc < 2000) begin
            if (!ld) iter_cyc++;
            cyc++;
            @(negedge aclk);
        end
        if (!pix_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (eiter_cyc >= 0) chk({tag, "_itercyc"}, 32'(iter_cyc), 32'(eiter_cyc));
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold"}, {pix_valid, ld, 6'(pix_x), 6'(pix_y), pix_iter, 8'(pix_inset)},
                {1'b1, 1'b0, 6'(ex), 6'(ey), 8'(eiter), 8'(einset)});
            @(negedge aclk);
        end
        chk({tag, "_x"}, 32'(pix_x), 32'(ex));
        chk({tag, "_y"}, 32'(pix_y), 32'(ey));
        chk({tag, "_iter"}, 32'(pix_iter), 32'(eiter));
        chk({tag, "_inset"}, 32'(pix_inset), 32'(einset));
        chk({tag, "_cre"}, c_re, ecre);
        chk({tag, "_cim"}, c_im, ecim);
        pix_ready = 1'b1;
        @(negedge aclk);
        pix_ready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; pix_ready = 1'b0;
        x_start = '0; y_start = '0; step = '0; width = '0; height = '0;
        repeat (3) @(negedge aclk);
        chk("rst_outs", {c_re[15:0], c_im[15:0]}, 32'd0);
        chk("rst_ctl", {27'd0, ld, pix_valid, busy, done, pix_inset}, {27'd0, 5'b10000});
        aresetn = 1'b1;

        // T1: c=3.0 escapes at k=1, single-pixel frame
        start_frame(32'h0060_0000, 32'd0, 32'd0, 1, 1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_ld_load", {31'd0, ld}, 32'd1);
        get_pix("t1", 0, 0, 1, 0, 32'h0060_0000, 32'd0, 2, 0);
        chk("t1_done", {30'd0, done, busy}, 32'b10);
        @(negedge aclk);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);

        // T2: c=1.0 -> z=1,2,5 -> escape at k=3
        start_frame(32'h0020_0000, 32'd0, 32'd0, 1, 1);
        get_pix("t2", 0, 0, 3, 0, 32'h0020_0000, 32'd0, 4, 0);

        // T3: c=0 and c=-2.0 stay bounded, capped at MAX_ITER
        start_frame(32'd0, 32'd0, 32'd0, 1, 1);
        get_pix("t3a", 0, 0, 255, 1, 32'd0, 32'd0, 256, 0);
        start_frame(32'hFFC0_0000, 32'd0, 32'd0, 1, 1);
        get_pix("t3b", 0, 0, 255, 1, 32'hFFC0_0000, 32'd0, 256, 0);
        chk("t3_done", {31'd0, done}, 32'd1);

        // T4: 2x2 raster order and c stepping across row/column
        start_frame(32'h0060_0000, 32'd0, 32'h0020_0000, 2, 2);
        get_pix("t4p00", 0, 0, 1, 0, 32'h0060_0000, 32'h0000_0000, 2, 0);
        chk("t4_nodone", {30'd0, done, busy}, 32'b01);
        get_pix("t4p10", 1, 0, 1, 0, 32'h0080_0000, 32'h0000_0000, 2, 0);
        get_pix("t4p01", 0, 1, 1, 0, 32'h0060_0000, 32'h0020_0000, 2, 0);
        get_pix("t4p11", 1, 1, 1, 0, 32'h0080_0000, 32'h0020_0000, 2, 0);
        chk("t4_done", {30'd0, done, busy}, 32'b10);

        // T5: backpressure for 10 cycles with a stray start while busy
        start_frame(32'h0020_0000, 32'hFFE0_0000, 32'h0020_0000, 1, 2);
        start = 1'b1;
        get_pix("t5p0", 0, 0, 2, 0, 32'h0020_0000, 32'hFFE0_0000, -1, 10);
        start = 1'b0;
        get_pix("t5p1", 0, 1, 3, 0, 32'h0020_0000, 32'h0000_0000, 4, 0);
        chk("t5_done", {30'd0, done, busy}, 32'b10);
        @(negedge aclk);
        chk("t5_idle", {30'd0, busy, pix_valid}, 32'd0);

        // T6: empty frame, then reset in the middle of an iteration
        @(negedge aclk);
        x_start = '0; y_start = '0; step = '0; width = '0; height = DIM_W'(4);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("t6_empty_done", {29'd0, done, busy, pix_valid}, 32'b100);
        @(negedge aclk);
        chk("t6_empty_pulse", {31'd0, done}, 32'd0);

        start_frame(32'd0, 32'h0010_0000, 32'd0, 3, 3);
        repeat (20) @(negedge aclk);
        chk("t6_midi", {30'd0, ld, busy}, 32'b01);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_rst_ctl", {27'd0, ld, pix_valid, busy, done, pix_inset}, {27'd0, 5'b10000});
        chk("t6_rst_c", c_re | c_im, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("t6_no_done", {30'd0, done, busy}, 32'd0);
        start_frame(32'h0060_0000, 32'd0, 32'h0020_0000, 2, 1);
        get_pix("t6p00", 0, 0, 1, 0, 32'h0060_0000, 32'd0, 2, 0);
        get_pix("t6p10", 1, 0, 1, 0, 32'h0080_0000, 32'd0, 2, 0);
        chk("t6_done", {30'd0, done, busy}, 32'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
